// File: rtl/aes_subbytes_seq_if.sv
// Valid/ready bus for the sequential SubBytes engine: block in, substituted block out, busy status.
interface aes_subbytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_subbytes_seq.sv
// Multi-cycle AES SubBytes/InvSubBytes over a 128-bit state, LANES bytes per cycle.
// Define SUBBYTES_SBOX_PIPE_EN to register S-box outputs before write-back (one extra RUN cycle).
module aes_subbytes_seq #(
    parameter int unsigned LANES = 4
) (
    input logic               clk,
    input logic               rst_n,
    aes_subbytes_seq_if.slave bus
);

    localparam int unsigned NumSteps = 16 / LANES;
    localparam int unsigned CntW     = (NumSteps > 1) ? $clog2(NumSteps) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumSteps - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SboxFwd = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse table derived at elaboration so the two can never disagree.
    function automatic logic [2047:0] invert_sbox(input logic [2047:0] fwd);
        logic [2047:0] inv;
        logic [7:0]    s;
        inv = '0;
        for (int i = 0; i < 256; i++) begin
            s = fwd[8*(255-i) +: 8];
            inv[8*(255-int'(s)) +: 8] = i[7:0];
        end
        return inv;
    endfunction

    localparam logic [2047:0] SboxInv = invert_sbox(SboxFwd);

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SboxFwd[8*(255-int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return SboxInv[8*(255-int'(b)) +: 8];
    endfunction

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [127:0]     work_q;
    logic             mode_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

`ifdef SUBBYTES_SBOX_PIPE_EN
    logic [8*LANES-1:0] pipe_q;
    logic [CntW-1:0]    wb_cnt_q;
    logic               pv_q;
    logic               lk_done_q;
`endif

    int unsigned        lk_base;
    int unsigned        wr_base;
    logic [7:0]         lk_byte;
    logic [8*LANES-1:0] sub_res;
    logic [8*LANES-1:0] wr_bytes;
    logic [127:0]       work_wb;

    always_comb begin
        lk_base = LANES * int'(cnt_q);
        lk_byte = '0;
        sub_res = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lk_byte = work_q[8*(lk_base+l) +: 8];
            sub_res[8*l +: 8] = mode_q ? sbox_inv(lk_byte) : sbox_fwd(lk_byte);
        end
`ifdef SUBBYTES_SBOX_PIPE_EN
        wr_base  = LANES * int'(wb_cnt_q);
        wr_bytes = pipe_q;
`else
        wr_base  = lk_base;
        wr_bytes = sub_res;
`endif
        work_wb = work_q;
        for (int l = 0; l < int'(LANES); l++) begin
            work_wb[8*(wr_base+l) +: 8] = wr_bytes[8*l +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            work_q      <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SUBBYTES_SBOX_PIPE_EN
            pipe_q      <= '0;
            wb_cnt_q    <= '0;
            pv_q        <= 1'b0;
            lk_done_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        work_q     <= bus.in_data;
                        mode_q     <= bus.in_inv;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
`ifdef SUBBYTES_SBOX_PIPE_EN
                        pv_q       <= 1'b0;
                        lk_done_q  <= 1'b0;
`endif
                    end
                end
                StRun: begin
`ifdef SUBBYTES_SBOX_PIPE_EN
                    // Lookup of step n and write-back of step n-1 touch disjoint bytes.
                    if (pv_q) begin
                        work_q <= work_wb;
                    end
                    if (!lk_done_q) begin
                        pipe_q    <= sub_res;
                        wb_cnt_q  <= cnt_q;
                        pv_q      <= 1'b1;
                        cnt_q     <= cnt_q + 1'b1;
                        lk_done_q <= (cnt_q == LastCnt);
                    end
                    if (pv_q && wb_cnt_q == LastCnt) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
`else
                    work_q <= work_wb;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
`endif
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = work_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Self-checking bench for aes_subbytes_seq: constant vectors, algebraic S-box model, scoreboard.
module tb_aes_subbytes_seq;

    localparam int unsigned LANES    = 4;
    localparam int unsigned NumSteps = 16 / LANES;
`ifdef SUBBYTES_SBOX_PIPE_EN
    localparam int ExpLat = int'(NumSteps) + 1;
`else
    localparam int ExpLat = int'(NumSteps);
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_subbytes_seq_if bus ();

    aes_subbytes_seq #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   fwd_tbl [256];
    logic [7:0]   inv_tbl [256];
    logic [127:0] sb_q [$];

    typedef struct {
        string        name;
        logic [127:0] data;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [7];

    // GF(2^8) arithmetic with the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gf_mul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] y, input int k);
        return (y << k) | (y >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = inv ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the engine idle; returns #1 after the accept edge.
    task automatic start_block(input string tag, input logic [127:0] d, input logic inv,
                               input logic [127:0] exp);
        check_bit({tag, ":in_ready_idle"}, bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_inv   = inv;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the engine must ignore them.
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_inv   = ~inv;
        check_bit({tag, ":busy_run"}, bus.busy, 1'b1);
        check_bit({tag, ":in_ready_run"}, bus.in_ready, 1'b0);
    endtask

    task automatic wait_out(input string tag);
        int           cyc;
        logic [127:0] exp;
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_int({tag, ":latency"}, cyc, ExpLat);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s:scoreboard: got output, want no pending block", tag);
        end else begin
            exp = sb_q.pop_front();
            check({tag, ":out_data"}, bus.out_data, exp);
        end
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_bit({tag, ":out_valid_drop"}, bus.out_valid, 1'b0);
        check_bit({tag, ":in_ready_back"}, bus.in_ready, 1'b1);
        check_bit({tag, ":busy_drop"}, bus.busy, 1'b0);
    endtask

    task automatic run_block(input string tag, input logic [127:0] d, input logic inv,
                             input logic [127:0] exp);
        start_block(tag, d, inv, exp);
        wait_out(tag);
        release_out(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        logic [127:0] ef;
        logic [127:0] ei;
        logic [127:0] held;

        for (int i = 0; i < 256; i++) fwd_tbl[i] = sbox_model(i[7:0]);
        for (int i = 0; i < 256; i++) inv_tbl[fwd_tbl[i]] = i[7:0];

        vecs[0] = '{"zero_fwd", 128'h0, 1'b0, {16{8'h63}}};
        vecs[1] = '{"b0153_fwd", 128'h0153, 1'b0, {{14{8'h63}}, 8'h7c, 8'hed}};
        vecs[2] = '{"b0153_inv", {{14{8'h63}}, 8'h7c, 8'hed}, 1'b1, 128'h0153};
        vecs[3] = '{"ones_fwd", {16{8'hff}}, 1'b0, {16{8'h16}}};
        vecs[4] = '{"zero_inv", 128'h0, 1'b1, {16{8'h52}}};
        vecs[5] = '{"fips_fwd", 128'h00102030405060708090a0b0c0d0e0f0, 1'b0,
                    128'h63cab7040953d051cd60e0e7ba70e18c};
        vecs[6] = '{"fips_inv", 128'h63cab7040953d051cd60e0e7ba70e18c, 1'b1,
                    128'h00102030405060708090a0b0c0d0e0f0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_inv    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset:in_ready", bus.in_ready, 1'b1);
        check_bit("reset:out_valid", bus.out_valid, 1'b0);
        check_bit("reset:busy", bus.busy, 1'b0);
        check("reset:out_data", bus.out_data, 128'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // out_ready while idle must not produce anything.
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_bit("idle_out_ready:out_valid", bus.out_valid, 1'b0);
        end
        bus.out_ready = 1'b0;

        foreach (vecs[i]) run_block(vecs[i].name, vecs[i].data, vecs[i].inv, vecs[i].exp);

        // All 256 byte values, round-tripped starting from each mode.
        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(blk * 16 + i);
            ef = sub_state(d, 1'b0);
            ei = sub_state(d, 1'b1);
            run_block("exh_fwd", d, 1'b0, ef);
            run_block("exh_fwd_back", ef, 1'b1, d);
            run_block("exh_inv", d, 1'b1, ei);
            run_block("exh_inv_back", ei, 1'b0, d);
        end

        // Backpressure in DONE: output held, new requests ignored.
        held = vecs[5].exp;
        start_block("hold", vecs[5].data, 1'b0, held);
        wait_out("hold");
        bus.in_valid = 1'b1;
        bus.in_data  = {16{8'haa}};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check_bit("hold:out_valid", bus.out_valid, 1'b1);
            check("hold:out_data", bus.out_data, held);
            check_bit("hold:in_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b0;
        release_out("hold");
        repeat (ExpLat + 3) begin
            @(posedge clk); #1;
            check_bit("not_queued:out_valid", bus.out_valid, 1'b0);
            check_bit("not_queued:busy", bus.busy, 1'b0);
        end

        // Reset in the second RUN cycle discards the block.
        start_block("rst_run", vecs[5].data, 1'b0, vecs[5].exp);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_bit("rst_run:out_valid", bus.out_valid, 1'b0);
        check_bit("rst_run:busy", bus.busy, 1'b0);
        check_bit("rst_run:in_ready", bus.in_ready, 1'b1);
        check("rst_run:out_data", bus.out_data, 128'h0);
        void'(sb_q.pop_front());
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block("after_rst_run", vecs[1].data, 1'b0, vecs[1].exp);

        // Reset while DONE drops out_valid without a clock edge.
        start_block("rst_done", vecs[3].data, 1'b0, vecs[3].exp);
        wait_out("rst_done");
        rst_n = 1'b0;
        #1;
        check_bit("rst_done:out_valid", bus.out_valid, 1'b0);
        check_bit("rst_done:in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block("after_rst_done", vecs[4].data, 1'b1, vecs[4].exp);

        check_int("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
